xram_resp: RTL and testbench

Byte-wide XRAM responder: the memory side of the XRAM strobe/ack bus that DMA initiators such as the memory-write engine drive. It latches a request, waits a parameterised number of wait states, then returns a one-cycle ack with read data or commits the write. It sits between the XIOMMU/initiators and the on-chip XRAM array and exports transfer counters for verification.

---
 rtl/xram_pkg.sv | 23 ++
 rtl/xram_sram.sv | 28 ++
 rtl/xram_resp.sv | 140 ++++++++++++++
 tb/tb_xram_resp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/xram_pkg.sv
// Shared definitions for the XRAM responder: bus widths, FSM encoding and
// the wait-counter load helper.
package xram_pkg;

    localparam int XRAM_ADDR_W = 16;
    localparam int XRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10,
        ST_BAD  = 2'b11
    } resp_state_t;

    // Where an illegal encoding goes on the next edge.
    localparam resp_state_t RECOVER_STATE = ST_IDLE;

    // Initial wait-counter value; unused when there are no wait states.
    function automatic logic [3:0] wait_load(input int w);
        return (w == 0) ? 4'd0 : 4'(w - 1);
    endfunction

endpackage

// File: rtl/xram_sram.sv
// Byte-wide backing store: synchronous write, registered read, no reset.
// Reads and writes are never issued in the same cycle by the responder.
module xram_sram #(
    parameter int DEPTH = 8192,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/xram_resp.sv
// XRAM strobe/ack responder: latches a request, waits WAIT cycles, then
// acks for one cycle with read data or commits the write on the closing edge.
import xram_pkg::*;

module xram_resp #(
    parameter int         DEPTH    = 8192,
    parameter int         WAIT     = 2,
    parameter logic [7:0] OOR_DATA = 8'hff
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XRAM_ADDR_W-1:0] xram_addr,
    input  logic [XRAM_DATA_W-1:0] xram_data_in,
    input  logic                   xram_stb,
    input  logic                   xram_wr,
    output logic [XRAM_DATA_W-1:0] xram_data_out,
    output logic                   xram_ack,
    output logic                   xram_err,
    output logic [1:0]             resp_state,
    output logic [15:0]            resp_rd_count,
    output logic [15:0]            resp_wr_count
);

    localparam int         MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WCNT_LOAD = wait_load(WAIT);

    resp_state_t             state_reg;
    logic [MEM_AW-1:0]       addr_reg;
    logic                    wr_reg;
    logic                    oor_reg;
    logic [3:0]              wcnt_reg;
    logic [15:0]             rd_count_reg;
    logic [15:0]             wr_count_reg;
    logic                    data_valid_reg;
    logic                    data_oor_reg;

    logic                    in_idle;
    logic                    addr_oor_in;
    logic                    enter_ack;
    logic                    req_wr;
    logic                    req_oor;
    logic [MEM_AW-1:0]       req_addr;
    logic                    sram_rd_en;
    logic                    sram_wr_en;
    logic [XRAM_DATA_W-1:0]  sram_rd_data;

    // Requests come straight off the bus in IDLE (zero-wait case), else from the latch.
    assign in_idle     = (state_reg == ST_IDLE);
    assign addr_oor_in = (32'(xram_addr) >= 32'(DEPTH));
    assign req_addr    = in_idle ? xram_addr[MEM_AW-1:0] : addr_reg;
    assign req_wr      = in_idle ? xram_wr     : wr_reg;
    assign req_oor     = in_idle ? addr_oor_in : oor_reg;

    assign enter_ack = xram_stb &&
                       ((in_idle && (WAIT == 0)) ||
                        ((state_reg == ST_WAIT) && (wcnt_reg == 4'd0)));

    assign xram_ack   = (state_reg == ST_ACK) && xram_stb;
    assign xram_err   = xram_ack && oor_reg;
    assign resp_state = state_reg;

    assign sram_rd_en = enter_ack && !req_wr && !req_oor;
    assign sram_wr_en = xram_ack && wr_reg && !oor_reg;

    assign xram_data_out = !data_valid_reg ? '0 :
                           data_oor_reg    ? OOR_DATA : sram_rd_data;
    assign resp_rd_count = rd_count_reg;
    assign resp_wr_count = wr_count_reg;

    xram_sram #(
        .DEPTH (DEPTH),
        .AW    (MEM_AW),
        .DW    (XRAM_DATA_W)
    ) u_sram (
        .clk     (clk),
        .rd_en   (sram_rd_en),
        .rd_addr (req_addr),
        .rd_data (sram_rd_data),
        .wr_en   (sram_wr_en),
        .wr_addr (addr_reg),
        .wr_data (xram_data_in)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            wr_reg         <= 1'b0;
            oor_reg        <= 1'b0;
            wcnt_reg       <= 4'd0;
            rd_count_reg   <= 16'd0;
            wr_count_reg   <= 16'd0;
            data_valid_reg <= 1'b0;
            data_oor_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (xram_stb) begin
                        addr_reg <= xram_addr[MEM_AW-1:0];
                        wr_reg   <= xram_wr;
                        oor_reg  <= addr_oor_in;
                        if (WAIT == 0) begin
                            state_reg <= ST_ACK;
                        end else begin
                            wcnt_reg  <= WCNT_LOAD;
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!xram_stb) begin
                        state_reg <= ST_IDLE;
                    end else if (wcnt_reg == 4'd0) begin
                        state_reg <= ST_ACK;
                    end else begin
                        wcnt_reg <= wcnt_reg - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    if (xram_ack) begin
                        if (wr_reg) begin
                            wr_count_reg <= wr_count_reg + 16'd1;
                        end else begin
                            rd_count_reg <= rd_count_reg + 16'd1;
                        end
                    end
                end
                default: state_reg <= RECOVER_STATE;
            endcase

            // Read data is captured on the edge entering ACK and then held.
            if (enter_ack && !req_wr) begin
                data_valid_reg <= 1'b1;
                data_oor_reg   <= req_oor;
            end
        end
    end

endmodule

// File: tb/tb_xram_resp.sv
// Directed bench: a WAIT=2 instance driven from a vector table plus
// hand-written abort/reset/wrap sequences, and a WAIT=0 instance for bursts.
module tb_xram_resp;

    logic        clk;
    logic        rst;

    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_din,  b_din;
    logic        a_stb,  b_stb;
    logic        a_wr,   b_wr;
    logic [7:0]  a_dout, b_dout;
    logic        a_ack,  b_ack;
    logic        a_err,  b_err;
    logic [1:0]  a_state, b_state;
    logic [15:0] a_rdc, a_wrc, b_rdc, b_wrc;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_rdc [2];
    logic [15:0] exp_wrc [2];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs [11];

    xram_resp #(.DEPTH(8192), .WAIT(2), .OOR_DATA(8'hff)) dut_a (
        .clk(clk), .rst(rst), .xram_addr(a_addr), .xram_data_in(a_din),
        .xram_stb(a_stb), .xram_wr(a_wr), .xram_data_out(a_dout),
        .xram_ack(a_ack), .xram_err(a_err), .resp_state(a_state),
        .resp_rd_count(a_rdc), .resp_wr_count(a_wrc)
    );

    xram_resp #(.DEPTH(8192), .WAIT(0), .OOR_DATA(8'hff)) dut_b (
        .clk(clk), .rst(rst), .xram_addr(b_addr), .xram_data_in(b_din),
        .xram_stb(b_stb), .xram_wr(b_wr), .xram_data_out(b_dout),
        .xram_ack(b_ack), .xram_err(b_err), .resp_state(b_state),
        .resp_rd_count(b_rdc), .resp_wr_count(b_wrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit stb, input bit wr,
                         input logic [15:0] addr, input logic [7:0] din);
        if (sel) begin
            b_stb = stb; b_wr = wr; b_addr = addr; b_din = din;
        end else begin
            a_stb = stb; a_wr = wr; a_addr = addr; a_din = din;
        end
    endtask

    // One complete transfer with stb held until ack; checks latency, err, data, counters.
    task automatic xfer(input bit sel, input bit wr, input logic [15:0] addr,
                        input logic [7:0] din, input logic [7:0] exp_data, input bit exp_err);
        int  n;
        bit  got;
        int  exp_lat;
        exp_lat = sel ? 1 : 3;
        got = 1'b0;
        @(posedge clk); #1;
        drive(sel, 1'b1, wr, addr, din);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((sel ? b_ack : a_ack) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_latency", n, exp_lat);
        if (got) begin
            check("ack_err", sel ? b_err : a_err, exp_err);
            if (!wr) check("read_data", sel ? b_dout : a_dout, exp_data);
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, addr, din);
        if (wr) exp_wrc[sel] = exp_wrc[sel] + 16'd1;
        else    exp_rdc[sel] = exp_rdc[sel] + 16'd1;
        @(negedge clk);
        check("rd_count", sel ? b_rdc : a_rdc, exp_rdc[sel]);
        check("wr_count", sel ? b_wrc : a_wrc, exp_wrc[sel]);
        $display("xfer dut=%0d %s addr=%h din=%h dout=%h err=%0d lat=%0d",
                 sel, wr ? "WR" : "RD", addr, din, sel ? b_dout : a_dout,
                 sel ? b_err : a_err, n);
    endtask

    initial begin
        int  k;
        int  cyc;
        bit  got;

        vecs[0]  = '{1'b1, 16'h0010, 8'h5a, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 8'h00, 8'h5a, 1'b0};
        vecs[2]  = '{1'b1, 16'h1e00, 8'h42, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 16'h2000, 8'h00, 8'hff, 1'b1};
        vecs[4]  = '{1'b1, 16'hfe00, 8'h77, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 16'h1e00, 8'h00, 8'h42, 1'b0};
        vecs[6]  = '{1'b1, 16'h1fff, 8'ha5, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 16'h1fff, 8'h00, 8'ha5, 1'b0};
        vecs[8]  = '{1'b1, 16'h0040, 8'h11, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 16'h0040, 8'h00, 8'h11, 1'b0};
        vecs[10] = '{1'b0, 16'hffff, 8'h00, 8'hff, 1'b1};

        exp_rdc[0] = 16'd0; exp_rdc[1] = 16'd0;
        exp_wrc[0] = 16'd0; exp_wrc[1] = 16'd0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", a_state, 2'b00);
        check("reset_ack", a_ack, 1'b0);
        check("reset_err", a_err, 1'b0);
        check("reset_dout", a_dout, 8'h00);
        check("reset_rdc", a_rdc, 16'h0);
        check("reset_wrc", a_wrc, 16'h0);
        check("reset_dout_b", b_dout, 8'h00);

        for (int i = 0; i < 11; i++) begin
            xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Abort: stb dropped during the second WAIT cycle.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_stb = 1'b0;
        @(negedge clk);
        check("abort_ack_wait", a_ack, 1'b0);
        check("abort_state_wait", a_state, 2'b01);
        @(negedge clk);
        check("abort_state_idle", a_state, 2'b00);
        check("abort_ack", a_ack, 1'b0);
        check("abort_rdc", a_rdc, exp_rdc[0]);
        check("abort_wrc", a_wrc, exp_wrc[0]);
        check("abort_dout_held", a_dout, 8'hff);
        $display("xfer dut=0 RD addr=0020 aborted state=%0d", a_state);

        // Reset during the ack cycle of a write: ack drops, write is lost.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 16'h0040, 8'h33);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("midrst_ack_seen", got, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_ack", a_ack, 1'b0);
        check("midrst_state", a_state, 2'b00);
        check("midrst_rdc", a_rdc, 16'h0);
        check("midrst_wrc", a_wrc, 16'h0);
        check("midrst_dout", a_dout, 8'h00);
        a_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdc[0] = 16'd0; exp_wrc[0] = 16'd0;
        exp_rdc[1] = 16'd0; exp_wrc[1] = 16'd0;
        $display("xfer dut=0 WR addr=0040 din=33 reset in ack");
        xfer(1'b0, 1'b0, 16'h0040, 8'h00, 8'h11, 1'b0);

        // Write counter wrap.
        @(negedge clk);
        force dut_a.wr_count_reg = 16'hffff;
        @(negedge clk);
        release dut_a.wr_count_reg;
        @(negedge clk);
        check("wrap_preload", a_wrc, 16'hffff);
        exp_wrc[0] = 16'hffff;
        xfer(1'b0, 1'b1, 16'h0050, 8'h99, 8'h00, 1'b0);
        check("wrap_zero", a_wrc, 16'h0000);

        // Zero-wait burst: preload, then four reads with stb held throughout.
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 1'b1, 16'(i), 8'(i + 1), 8'h00, 1'b0);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            if (b_ack === 1'b1) begin
                check("burst_cycle", cyc, 1 + 2 * k);
                check("burst_data", b_dout, 8'(k + 1));
                $display("xfer dut=1 RD burst addr=%h dout=%h cycle=%0d", b_addr, b_dout, cyc);
                k++;
            end
            @(posedge clk); #1;
            if (k < 4) b_addr = 16'(k);
            else       b_stb = 1'b0;
            cyc++;
        end
        check("burst_acks", k, 4);
        @(negedge clk);
        check("burst_rdc", b_rdc, 16'd4);
        check("burst_wrc", b_wrc, 16'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
